// File: rtl/rx_drain_arb_pkg.sv
// Shared types and helpers for the RX FIFO drain arbiter: FSM encoding,
// index-width helper and the rotate-priority search used by rr_pick.
package rx_drain_arb_pkg;

   localparam int unsigned RR_MAX_N = 8;
   localparam int unsigned RR_IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Returns {found, index} of the first set bit of mask at or above start+1, wrapping at n.
   function automatic logic [RR_IDX_W:0] rr_first(input logic [RR_MAX_N-1:0] mask,
                                                  input logic [RR_IDX_W-1:0] start,
                                                  input int unsigned         n);
      logic                found;
      logic [RR_IDX_W-1:0] idx;
      int unsigned         k;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= RR_MAX_N; i++) begin
         if (i <= n) begin
            k = (32'(start) + i) % n;
            if (!found && mask[k[RR_IDX_W-1:0]]) begin
               found = 1'b1;
               idx   = k[RR_IDX_W-1:0];
            end
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/rx_drain_arb_rr_pick.sv
// Combinational rotate-priority encoder: first requester after i_last, wrapping.
module rr_pick
   import rx_drain_arb_pkg::*;
#(
   parameter  int unsigned NSM = 4,
   localparam int unsigned IW  = idx_w(NSM)
) (
   input  logic [NSM-1:0] i_req,
   input  logic [IW-1:0]  i_last,
   output logic [IW-1:0]  o_grant,
   output logic           o_found
);

   logic [RR_MAX_N-1:0] w_mask;
   logic [RR_IDX_W:0]   w_res;

   always_comb begin
      w_mask          = '0;
      w_mask[NSM-1:0] = i_req;
      w_res           = rr_first(w_mask, RR_IDX_W'(i_last), NSM);
      o_found         = w_res[RR_IDX_W];
      o_grant         = IW'(w_res[RR_IDX_W-1:0]);
   end

endmodule

// File: rtl/rx_drain_arb.sv
// Round-robin burst drain of NSM RX FIFOs onto one registered valid/ready stream.
// Optional RX_DRAIN_STATS_EN adds per-SM saturating word counters (stat_words, stat_clr).
module rx_drain_arb
   import rx_drain_arb_pkg::*;
#(
   parameter  int unsigned NSM       = 4,
   parameter  int unsigned WIDTH     = 32,
   parameter  int unsigned BURST_LEN = 4,
   localparam int unsigned IW        = idx_w(NSM),
   localparam int unsigned CW        = $clog2(BURST_LEN) + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NSM-1:0]       sm_en,
   input  logic [NSM-1:0]       rx_empty,
   input  logic [NSM*WIDTH-1:0] rx_data,
   output logic [NSM-1:0]       rx_pull,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [IW-1:0]        out_sm,
   output logic                 busy
`ifdef RX_DRAIN_STATS_EN
   ,
   output logic [NSM*16-1:0]    stat_words,
   input  logic                 stat_clr
`endif
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IW-1:0]    r_grant;
   logic [IW-1:0]    r_last;
   logic [IW-1:0]    w_pick;
   logic             w_found;
   logic [CW-1:0]    r_cnt;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [IW-1:0]    r_out_sm;
   logic [WIDTH-1:0] w_head;
   logic [NSM-1:0]   w_req;
   logic             w_req_g;
   logic             w_slot_free;
   logic             w_xfer;
   logic             w_last_word;

   assign w_req = sm_en & ~rx_empty;

   rr_pick #(.NSM(NSM)) u_pick (
      .i_req   (w_req),
      .i_last  (r_last),
      .o_grant (w_pick),
      .o_found (w_found)
   );

   always_comb begin
      w_head  = '0;
      w_req_g = 1'b0;
      for (int unsigned i = 0; i < NSM; i++) begin
         if (IW'(i) == r_grant) begin
            w_head  = rx_data[i*WIDTH +: WIDTH];
            w_req_g = w_req[i];
         end
      end
   end

   assign w_slot_free = !r_out_valid || out_ready;
   assign w_xfer      = (r_state == ST_BURST) && w_req_g && w_slot_free;
   assign w_last_word = (r_cnt == CW'(BURST_LEN - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // A stalled slot with the FIFO still requesting keeps the burst open.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_found) w_state_nxt = ST_BURST;
         ST_BURST: if (!w_req_g || (w_xfer && w_last_word)) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_pull = '0;
      if (w_xfer) rx_pull[r_grant] = 1'b1;
      busy = (r_state == ST_BURST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_grant     <= '0;
         r_last      <= IW'(NSM - 1);
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sm    <= '0;
      end else begin
         if (r_state == ST_IDLE && w_found) begin
            r_grant <= w_pick;
            r_cnt   <= '0;
         end
         if (w_xfer) begin
            r_out_data  <= w_head;
            r_out_sm    <= r_grant;
            r_out_valid <= 1'b1;
            r_cnt       <= r_cnt + CW'(1);
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (r_state == ST_BURST && w_state_nxt == ST_IDLE) r_last <= r_grant;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sm    = r_out_sm;

`ifdef RX_DRAIN_STATS_EN
   logic [15:0] r_stat [NSM];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NSM; i++) r_stat[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NSM; i++) begin
            if (stat_clr)                             r_stat[i] <= '0;
            else if (rx_pull[i] && r_stat[i] != '1)   r_stat[i] <= r_stat[i] + 16'd1;
         end
      end
   end

   always_comb begin
      stat_words = '0;
      for (int unsigned i = 0; i < NSM; i++) stat_words[i*16 +: 16] = r_stat[i];
   end
`endif

endmodule

// File: tb/tb_rx_drain_arb.sv
// Self-checking bench for rx_drain_arb: queue-backed FIFOs, burst-level reference model.
module tb_rx_drain_arb;

   localparam int NSM = 4;
   localparam int W   = 32;
   localparam int BL  = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NSM-1:0]   sm_en, rx_empty, rx_pull;
   logic [NSM*W-1:0] rx_data;
   logic             out_valid, out_ready, busy;
   logic [W-1:0]     out_data;
   logic [1:0]       out_sm;
`ifdef RX_DRAIN_STATS_EN
   logic [NSM*16-1:0] stat_words;
   logic              stat_clr;
`endif

   rx_drain_arb #(.NSM(NSM), .WIDTH(W), .BURST_LEN(BL)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sm_en     (sm_en),
      .rx_empty  (rx_empty),
      .rx_data   (rx_data),
      .rx_pull   (rx_pull),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sm    (out_sm),
      .busy      (busy)
`ifdef RX_DRAIN_STATS_EN
      ,
      .stat_words (stat_words),
      .stat_clr   (stat_clr)
`endif
   );

   always #5 clk = ~clk;

   logic [W-1:0]   fq [NSM][$];
   logic [NSM-1:0] pull_lat = '0;
   int unsigned    cyc = 0;
   logic [1:0]     obs_sm [$];
   logic [W-1:0]   obs_d  [$];
   int             obs_t  [$];
   logic [1:0]     exp_sm [$];
   logic [W-1:0]   exp_d  [$];
   int             exp_gap[$];
   int             obs_base = 0;
   int             m_last   = NSM - 1;
   int             n_vec = 0, n_err = 0, inv_err = 0;

   // FIFO emulation: pop what was pulled during the previous cycle, then present new heads.
   always @(posedge clk) begin
      cyc++;
      #1;
      for (int i = 0; i < NSM; i++) begin
         if (pull_lat[i] && fq[i].size() != 0) void'(fq[i].pop_front());
         rx_empty[i] = (fq[i].size() == 0);
         rx_data[i*W +: W] = rx_empty[i] ? '0 : fq[i][0];
      end
   end

   always @(negedge clk) begin
      pull_lat = rx_pull;
      if (reset_n === 1'b1) begin
         if (!$onehot0(rx_pull)) inv_err++;
         if ((rx_pull & ~(sm_en & ~rx_empty)) != '0) inv_err++;
         if (rx_pull != '0 && !busy) inv_err++;
         if (out_valid && out_ready) begin
            obs_sm.push_back(out_sm);
            obs_d.push_back(out_data);
            obs_t.push_back(int'(cyc));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_obs(input int n, input int budget, input bit rnd, output bit to);
      to = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (obs_sm.size() - obs_base >= n) begin
            to = 1'b0;
            break;
         end
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      out_ready = 1'b1;
   endtask

   // Reference: whole bursts chosen round-robin from a static snapshot of the FIFOs.
   task automatic model(input logic [NSM-1:0] en);
      int len [NSM];
      int pos [NSM];
      int prev_n, pick, n, c;
      bit first;
      exp_sm.delete(); exp_d.delete(); exp_gap.delete();
      for (int i = 0; i < NSM; i++) begin
         len[i] = en[i] ? fq[i].size() : 0;
         pos[i] = 0;
      end
      prev_n = BL;
      first  = 1'b1;
      forever begin
         pick = -1;
         for (int k = 1; k <= NSM; k++) begin
            c = (m_last + k) % NSM;
            if (pick < 0 && pos[c] < len[c]) pick = c;
         end
         if (pick < 0) break;
         n = (len[pick] - pos[pick] < BL) ? len[pick] - pos[pick] : BL;
         for (int j = 0; j < n; j++) begin
            exp_sm.push_back(2'(pick));
            exp_d.push_back(fq[pick][pos[pick] + j]);
            exp_gap.push_back(j > 0 ? 1 : (first ? 0 : (prev_n == BL ? 2 : 3)));
         end
         pos[pick] += n;
         prev_n = n;
         first  = 1'b0;
         m_last = pick;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; sm_en = '0; out_ready = 1'b1;
`ifdef RX_DRAIN_STATS_EN
      stat_clr = 1'b0;
`endif
      tick(); tick();
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || rx_pull !== '0) begin
         n_err++; $display("FAIL reset_ctl: valid=%b busy=%b pull=%b, want 0 0 0000", out_valid, busy, rx_pull);
      end
      n_vec++;
      if (out_data !== '0 || out_sm !== 2'd0) begin
         n_err++; $display("FAIL reset_data: data=%h sm=%0d, want 0 0", out_data, out_sm);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_sm();
      logic [W-1:0] want [3];
      want[0] = 32'hA1; want[1] = 32'hA2; want[2] = 32'hA3;
      sm_en = '0;
      for (int j = 0; j < 3; j++) fq[2].push_back(want[j]);
      tick();
      sm_en = 4'hF;
      tick();
      n_vec++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL single_grant: busy=%b valid=%b, want 1 0", busy, out_valid);
      end
      for (int j = 0; j < 3; j++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== want[j] || out_sm !== 2'd2) begin
            n_err++; $display("FAIL single_word%0d: valid=%b data=%h sm=%0d, want 1 %h 2", j, out_valid, out_data, out_sm, want[j]);
         end
      end
      tick();
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || rx_pull !== '0) begin
         n_err++; $display("FAIL single_end: busy=%b valid=%b pull=%b, want 0 0 0000", busy, out_valid, rx_pull);
      end
      m_last = 2;
   endtask

   task automatic test_round_robin();
      bit to;
      logic [1:0] gs; logic [W-1:0] gd;
      sm_en = '0;
      for (int i = 0; i < NSM; i++)
         for (int j = 0; j < 6; j++) fq[i].push_back($urandom);
      tick();
      sm_en = 4'hF;
      obs_base = obs_sm.size();
      model(4'hF);
      wait_obs(exp_sm.size(), 200, 1'b0, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL rr_timeout: got %0d words, want %0d", obs_sm.size() - obs_base, exp_sm.size()); end
      for (int j = 0; j < exp_sm.size(); j++) begin
         gs = 'x; gd = 'x;
         if (obs_base + j < obs_sm.size()) begin gs = obs_sm[obs_base + j]; gd = obs_d[obs_base + j]; end
         n_vec++;
         if (gs !== exp_sm[j] || gd !== exp_d[j]) begin
            n_err++; $display("FAIL rr_word%0d: got sm%0d/%h, want sm%0d/%h", j, gs, gd, exp_sm[j], exp_d[j]);
         end
         if (j > 0 && obs_base + j < obs_sm.size()) begin
            n_vec++;
            if (obs_t[obs_base + j] - obs_t[obs_base + j - 1] !== exp_gap[j]) begin
               n_err++; $display("FAIL rr_gap%0d: got %0d cycles, want %0d", j, obs_t[obs_base + j] - obs_t[obs_base + j - 1], exp_gap[j]);
            end
         end
      end
      tick(); tick();
   endtask

   task automatic test_stall();
      bit to;
      logic [1:0] gs; logic [W-1:0] gd;
      sm_en = '0;
      for (int j = 0; j < 6; j++) fq[1].push_back($urandom);
      tick();
      sm_en = 4'hF;
      obs_base = obs_sm.size();
      model(4'hF);
      wait_obs(2, 40, 1'b0, to);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== exp_d[2] || rx_pull !== '0 || busy !== 1'b1) begin
            n_err++; $display("FAIL stall_hold%0d: valid=%b data=%h pull=%b busy=%b, want 1 %h 0000 1", c, out_valid, out_data, rx_pull, busy, exp_d[2]);
         end
      end
      out_ready = 1'b1;
      wait_obs(exp_sm.size(), 80, 1'b0, to);
      tick(); tick(); tick();
      n_vec++;
      if (to || obs_sm.size() - obs_base != exp_sm.size()) begin
         n_err++; $display("FAIL stall_count: got %0d words, want %0d", obs_sm.size() - obs_base, exp_sm.size());
      end
      for (int j = 0; j < exp_sm.size(); j++) begin
         gs = 'x; gd = 'x;
         if (obs_base + j < obs_sm.size()) begin gs = obs_sm[obs_base + j]; gd = obs_d[obs_base + j]; end
         n_vec++;
         if (gs !== exp_sm[j] || gd !== exp_d[j]) begin
            n_err++; $display("FAIL stall_word%0d: got sm%0d/%h, want sm%0d/%h", j, gs, gd, exp_sm[j], exp_d[j]);
         end
      end
   endtask

   task automatic test_sm_disable();
      bit to;
      logic [1:0] gs; logic [W-1:0] gd;
      sm_en = '0;
      for (int j = 0; j < 2; j++) fq[0].push_back($urandom);
      for (int j = 0; j < 3; j++) fq[1].push_back($urandom);
      for (int j = 0; j < 2; j++) fq[2].push_back($urandom);
      tick();
      sm_en = 4'b1101;
      obs_base = obs_sm.size();
      model(4'b1101);
      wait_obs(exp_sm.size(), 80, 1'b0, to);
      for (int j = 0; j < exp_sm.size(); j++) begin
         gs = 'x; gd = 'x;
         if (obs_base + j < obs_sm.size()) begin gs = obs_sm[obs_base + j]; gd = obs_d[obs_base + j]; end
         n_vec++;
         if (gs !== exp_sm[j] || gd !== exp_d[j]) begin
            n_err++; $display("FAIL dis_word%0d: got sm%0d/%h, want sm%0d/%h", j, gs, gd, exp_sm[j], exp_d[j]);
         end
      end
      for (int c = 0; c < 4; c++) tick();
      n_vec++;
      if (fq[1].size() != 3 || busy !== 1'b0) begin
         n_err++; $display("FAIL dis_untouched: sm1 depth=%0d busy=%b, want 3 0", fq[1].size(), busy);
      end
      sm_en = 4'hF;
      obs_base = obs_sm.size();
      model(4'hF);
      wait_obs(exp_sm.size(), 40, 1'b0, to);
      gs = 'x;
      if (obs_base < obs_sm.size()) gs = obs_sm[obs_base];
      n_vec++;
      if (to || gs !== 2'd1 || fq[1].size() != 0) begin
         n_err++; $display("FAIL en_regrant: first sm=%0d depth=%0d, want 1 0", gs, fq[1].size());
      end
      tick(); tick();
   endtask

   task automatic test_disable_mid_burst();
      bit to;
      logic [W-1:0] d [4];
      logic [1:0] gs; logic [W-1:0] gd;
      sm_en = '0;
      for (int j = 0; j < 4; j++) begin d[j] = $urandom; fq[0].push_back(d[j]); end
      tick();
      sm_en = 4'hF;
      obs_base = obs_sm.size();
      for (int c = 0; c < 10 && out_valid !== 1'b1; c++) tick();
      sm_en = 4'b1110;
      for (int c = 0; c < 4; c++) tick();
      gd = 'x;
      if (obs_base < obs_sm.size()) gd = obs_d[obs_base];
      n_vec++;
      if (obs_sm.size() - obs_base != 1 || gd !== d[0] || fq[0].size() != 3 || busy !== 1'b0) begin
         n_err++; $display("FAIL mid_dis: words=%0d first=%h depth=%0d busy=%b, want 1 %h 3 0", obs_sm.size() - obs_base, gd, fq[0].size(), busy, d[0]);
      end
      m_last = 0;
      sm_en = 4'hF;
      obs_base = obs_sm.size();
      model(4'hF);
      wait_obs(exp_sm.size(), 40, 1'b0, to);
      for (int j = 0; j < exp_sm.size(); j++) begin
         gs = 'x; gd = 'x;
         if (obs_base + j < obs_sm.size()) begin gs = obs_sm[obs_base + j]; gd = obs_d[obs_base + j]; end
         n_vec++;
         if (gs !== exp_sm[j] || gd !== exp_d[j] || gd !== d[j + 1]) begin
            n_err++; $display("FAIL mid_rest%0d: got sm%0d/%h, want sm%0d/%h", j, gs, gd, exp_sm[j], d[j + 1]);
         end
      end
      tick(); tick();
   endtask

   task automatic test_async_reset();
      bit to;
      logic [1:0] gs; logic [W-1:0] gd;
      sm_en = '0;
      for (int j = 0; j < 4; j++) begin fq[2].push_back($urandom); fq[3].push_back($urandom); end
      tick();
      sm_en = 4'hF;
      for (int c = 0; c < 10 && out_valid !== 1'b1; c++) tick();
      #1 reset_n = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || rx_pull !== '0 || out_data !== '0) begin
         n_err++; $display("FAIL async_rst: valid=%b busy=%b pull=%b data=%h, want 0 0 0000 0", out_valid, busy, rx_pull, out_data);
      end
      for (int j = 0; j < 3; j++) fq[0].push_back($urandom);
      tick(); tick();
      reset_n = 1'b1;
      m_last = NSM - 1;
      obs_base = obs_sm.size();
      model(4'hF);
      wait_obs(exp_sm.size(), 120, 1'b0, to);
      gs = 'x;
      if (obs_base < obs_sm.size()) gs = obs_sm[obs_base];
      n_vec++;
      if (gs !== 2'd0) begin
         n_err++; $display("FAIL rst_first: first sm=%0d, want 0", gs);
      end
      for (int j = 0; j < exp_sm.size(); j++) begin
         gs = 'x; gd = 'x;
         if (obs_base + j < obs_sm.size()) begin gs = obs_sm[obs_base + j]; gd = obs_d[obs_base + j]; end
         n_vec++;
         if (gs !== exp_sm[j] || gd !== exp_d[j]) begin
            n_err++; $display("FAIL rst_word%0d: got sm%0d/%h, want sm%0d/%h", j, gs, gd, exp_sm[j], exp_d[j]);
         end
      end
      tick(); tick();
   endtask

   task automatic test_random(input int scenarios);
      bit to;
      logic [NSM-1:0] en;
      logic [1:0] gs; logic [W-1:0] gd;
      for (int s = 0; s <= scenarios; s++) begin
         sm_en = '0;
         en = (s == scenarios) ? 4'hF : 4'($urandom_range(0, 15));
         if (s < scenarios)
            for (int i = 0; i < NSM; i++)
               if ($urandom_range(0, 1) != 0)
                  for (int j = 0; j < int'($urandom_range(0, 5)); j++) fq[i].push_back($urandom);
         tick();
         sm_en = en;
         obs_base = obs_sm.size();
         model(en);
         wait_obs(exp_sm.size(), exp_sm.size() * 12 + 40, 1'b1, to);
         for (int j = 0; j < exp_sm.size(); j++) begin
            gs = 'x; gd = 'x;
            if (obs_base + j < obs_sm.size()) begin gs = obs_sm[obs_base + j]; gd = obs_d[obs_base + j]; end
            n_vec++;
            if (gs !== exp_sm[j] || gd !== exp_d[j]) begin
               n_err++; $display("FAIL rand%0d_word%0d: got sm%0d/%h, want sm%0d/%h", s, j, gs, gd, exp_sm[j], exp_d[j]);
            end
         end
         tick(); tick(); tick();
         n_vec++;
         if (to || busy !== 1'b0 || obs_sm.size() - obs_base != exp_sm.size()) begin
            n_err++; $display("FAIL rand%0d_end: busy=%b words=%0d, want 0 %0d", s, busy, obs_sm.size() - obs_base, exp_sm.size());
         end
      end
      n_vec++;
      if (inv_err !== 0) begin
         n_err++; $display("FAIL pull_rules: %0d bad rx_pull cycles, want 0", inv_err);
      end
   endtask

`ifdef RX_DRAIN_STATS_EN
   task automatic test_stats();
      bit to;
      stat_clr = 1'b1; tick(); stat_clr = 1'b0;
      sm_en = '0;
      for (int j = 0; j < 7; j++) fq[3].push_back($urandom);
      tick();
      sm_en = 4'hF;
      obs_base = obs_sm.size();
      wait_obs(7, 60, 1'b0, to);
      tick(); tick();
      n_vec++;
      if (to || stat_words !== {16'd7, 16'd0, 16'd0, 16'd0}) begin
         n_err++; $display("FAIL stats_count: got %h, want %h", stat_words, {16'd7, 16'd0, 16'd0, 16'd0});
      end
      stat_clr = 1'b1; tick(); stat_clr = 1'b0;
      n_vec++;
      if (stat_words !== '0) begin
         n_err++; $display("FAIL stats_clr: got %h, want 0", stat_words);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_sm();
      test_round_robin();
      test_stall();
      test_sm_disable();
      test_disable_mid_burst();
      test_async_reset();
      test_random(16);
`ifdef RX_DRAIN_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
